memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
//
// Fixed-latency word-array memory model that answers a control unit's
// requests. A request is captured in IDLE. The block waits LATENCY cycles
// and then raises MEM_R for one cycle (READY). Reads load DATA_OUT on the
// edge that enters READY. Writes commit to the array on the edge that
// leaves READY.
//
// Handshake: the control unit holds MIO_EN high from the request cycle until
// MEM_R is seen. Dropping MIO_EN while waiting cancels the access. MEM_R is a
// single-cycle strobe decoded from the state register. MIO_EN is ignored
// during that READY cycle, and the following IDLE cycle may accept a new
// request.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   MIO_EN     access request / keep-alive while waiting
//   R_W        1 = write, 0 = read (captured with the request)
//   SIZE       00 byte, 01 halfword, 10/11 word
//   SIGNED     sign-extend byte/halfword reads when 1
//   ADDR       byte address (little-endian lanes)
//   DATA_IN    write data, right-justified
//   DATA_OUT   registered, extended read data
//   MEM_R      ready strobe (state == READY)
//   MISALIGN   low address bits inconsistent with SIZE (meaningful with MEM_R)
//   BUSY       state != IDLE
//   state_dbg  current FSM state for observation
// ---------------------------------------------------------------------------
module memory_responder #(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        MEM_R,
    output logic        MISALIGN,
    output logic        BUSY,
    output logic [1:0]  state_dbg
);

    localparam int         AW       = DEPTH_LOG2 + 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [1:0]    size_q, size_d;
    logic          sgn_q, sgn_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   din_q, din_d;
    logic [31:0]   dout_q, dout_d;
    logic          enter_ready;

    // Word array; intentionally not reset.
    logic [31:0]   mem_q [2**DEPTH_LOG2];

    logic [31:0]   rd_word;
    logic [31:0]   rd_data;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [3:0]    wr_be;
    logic [31:0]   wr_lanes;
    logic          wr_en;

    // Address bits above the array are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDR[31:AW];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        addr_d      = addr_q;
        din_d       = din_q;
        enter_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MIO_EN) begin
                    rw_d   = R_W;
                    size_d = SIZE;
                    sgn_d  = SIGNED;
                    addr_d = ADDR[AW-1:0];
                    din_d  = DATA_IN;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d     = ST_READY;
                        enter_ready = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!MIO_EN) begin
                    // Abort: nothing is written and DATA_OUT keeps its value.
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d     = ST_READY;
                        enter_ready = 1'b1;
                    end
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Read path. The *_d request fields are correct on the edge that enters
    // READY, whether that comes from IDLE (LATENCY=1) or from WAIT.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_word = mem_q[addr_d[AW-1:2]];
        rd_byte = rd_word[{addr_d[1:0], 3'b000} +: 8];
        rd_half = addr_d[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_d)
            2'b00:   rd_data = {{24{sgn_d & rd_byte[7]}}, rd_byte};
            2'b01:   rd_data = {{16{sgn_d & rd_half[15]}}, rd_half};
            default: rd_data = rd_word;
        endcase
        dout_d = (enter_ready && !rw_d) ? rd_data : dout_q;
    end

    // -----------------------------------------------------------------------
    // Write path. Replicating the right-justified data across all lanes lets
    // the byte enables alone pick the destination.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = din_q;
        case (size_q)
            2'b00: begin
                wr_be[addr_q[1:0]] = 1'b1;
                wr_lanes           = {4{din_q[7:0]}};
            end
            2'b01: begin
                wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{din_q[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = din_q;
            end
        endcase
        wr_en = (state_q == ST_READY) && rw_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[addr_q[AW-1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= 32'h0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, all decoded from registers
    // -----------------------------------------------------------------------
    assign DATA_OUT  = dout_q;
    assign MEM_R     = (state_q == ST_READY);
    assign BUSY      = (state_q != ST_IDLE);
    assign MISALIGN  = MEM_R &&
                       (((size_q == 2'b01) && addr_q[0]) ||
                        (size_q[1] && (addr_q[1:0] != 2'b00)));
    assign state_dbg = state_q;

endmodule
